// File: rtl/pkt_ingress_alloc_if.sv
// Bundle of the RX stream, free-list, packet-buffer, parser and counter signals
// around pkt_ingress_alloc; master is the allocator side, slave the surroundings.
interface pkt_ingress_alloc_if #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned EMPTY_W    = 6,
  parameter int unsigned PKT_AWIDTH = 12,
  parameter int unsigned SLOT_LOG2  = 5,
  parameter int unsigned TAIL_BYTES = 7
);
  localparam int unsigned META_W = PKT_AWIDTH + SLOT_LOG2 + 1 + EMPTY_W + 8 * TAIL_BYTES;

  logic                            eth_valid;
  logic                            eth_sop;
  logic                            eth_eop;
  logic [DATA_W-1:0]               eth_data;
  logic [EMPTY_W-1:0]              eth_empty;
  logic [PKT_AWIDTH-1:0]           emptylist_out_data;
  logic                            emptylist_out_valid;
  logic                            emptylist_out_ready;
  logic [PKT_AWIDTH-1:0]           pktid_free_data;
  logic                            pktid_free_valid;
  logic [PKT_AWIDTH+SLOT_LOG2-1:0] pkt_buffer_address;
  logic                            pkt_buffer_write;
  logic [2+EMPTY_W+DATA_W-1:0]     pkt_buffer_writedata;
  logic                            pkt_valid;
  logic                            pkt_sop;
  logic                            pkt_eop;
  logic [DATA_W-1:0]               pkt_data;
  logic [EMPTY_W-1:0]              pkt_empty;
  logic                            pkt_ready;
  logic                            meta_valid;
  logic [META_W-1:0]               meta_data;
  logic                            meta_ready;
  logic [31:0]                     cnt_drop_noslot;
  logic [31:0]                     cnt_drop_oversize;
  logic [31:0]                     cnt_drop_full;

  modport master (
    input  eth_valid, eth_sop, eth_eop, eth_data, eth_empty,
    input  emptylist_out_data, emptylist_out_valid,
    output emptylist_out_ready,
    output pktid_free_data, pktid_free_valid,
    output pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
    output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_empty,
    input  pkt_ready,
    output meta_valid, meta_data,
    input  meta_ready,
    output cnt_drop_noslot, cnt_drop_oversize, cnt_drop_full
  );

  modport slave (
    output eth_valid, eth_sop, eth_eop, eth_data, eth_empty,
    output emptylist_out_data, emptylist_out_valid,
    input  emptylist_out_ready,
    input  pktid_free_data, pktid_free_valid,
    input  pkt_buffer_address, pkt_buffer_write, pkt_buffer_writedata,
    input  pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_empty,
    output pkt_ready,
    input  meta_valid, meta_data,
    output meta_ready,
    input  cnt_drop_noslot, cnt_drop_oversize, cnt_drop_full
  );
endinterface

// File: rtl/pkt_ingress_alloc.sv
// Ingress allocator: takes a free-list slot per RX packet, writes every flit into it and
// queues header + metadata for the parser; unsafe packets are dropped, counted and freed.
module pkt_ingress_alloc #(
  parameter int unsigned DATA_W        = 512,
  parameter int unsigned EMPTY_W       = 6,
  parameter int unsigned PKT_AWIDTH    = 12,
  parameter int unsigned SLOT_LOG2     = 5,
  parameter int unsigned TAIL_BYTES    = 7,
  parameter int unsigned OUT_DEPTH     = 8,
  parameter int unsigned LOCK_ON_EMPTY = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  pkt_ingress_alloc_if.master bus
);
  localparam int unsigned CW        = SLOT_LOG2 + 1;
  localparam int unsigned MAX_FLITS = 1 << SLOT_LOG2;
  localparam int unsigned TAIL_W    = 8 * TAIL_BYTES;
  localparam int unsigned ADDR_W    = PKT_AWIDTH + SLOT_LOG2;
  localparam int unsigned WD_W      = 2 + EMPTY_W + DATA_W;
  localparam int unsigned PW        = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W     = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PKT  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_LOCK = 2'd3;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pktID;
    logic [CW-1:0]         flits;
    logic [EMPTY_W-1:0]    empty;
    logic [TAIL_W-1:0]     last_7_bytes;
  } metadata_t;

  logic [1:0]            state_q, state_d;
  logic [PKT_AWIDTH-1:0] slot_q, slot_d;
  logic                  held_q, held_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]     hdr_q, hdr_d, prev_q, prev_d;

  logic                  el_ready, wr_en, fin, room, push_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  free_a, free_b, inc_noslot, inc_over, inc_full;
  logic [PKT_AWIDTH-1:0] fin_id;
  logic [2*DATA_W-1:0]   tail_src;
  logic [DATA_W-1:0]     push_hdr;
  metadata_t             push_meta;

  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WD_W-1:0]       wdata_q;

  logic                  push_q;
  logic [DATA_W-1:0]     push_hdr_q;
  metadata_t             push_meta_q;

  logic                  free_v, free_q, pend_q, pend_d;
  logic [PKT_AWIDTH-1:0] free_id, free_id_q, pend_id_q, pend_id_d;

  logic [DATA_W-1:0]     hdr_mem  [OUT_DEPTH];
  metadata_t             meta_mem [OUT_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic                  fifo_valid, pop;

  logic [31:0]           cnt_noslot_q, cnt_over_q, cnt_full_q;

  // Room counts the entry still sitting in the push stage; a same-cycle pop is not credited.
  assign room       = (32'(fifo_cnt_q) + 32'(push_q)) < OUT_DEPTH;
  assign fifo_valid = (fifo_cnt_q != '0);
  assign pop        = fifo_valid && bus.pkt_ready && bus.meta_ready;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    prev_d     = prev_q;
    el_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    fin        = 1'b0;
    free_a     = 1'b0;
    inc_noslot = 1'b0;
    inc_over   = 1'b0;
    if (bus.eth_valid && state_q != S_LOCK) begin
      if (bus.eth_sop) begin
        // A sop always retires whatever packet is still open before starting the new one.
        if (state_q == S_PKT || (state_q == S_DROP && held_q)) begin
          free_a   = 1'b1;
          inc_over = 1'b1;
        end
        state_d = S_IDLE;
        held_d  = 1'b0;
        if (bus.emptylist_out_valid) begin
          el_ready = 1'b1;
          slot_d   = bus.emptylist_out_data;
          hdr_d    = bus.eth_data;
          prev_d   = bus.eth_data;
          cnt_d    = CW'(1);
          wr_en    = 1'b1;
          wr_addr  = {bus.emptylist_out_data, {SLOT_LOG2{1'b0}}};
          if (bus.eth_eop) begin
            fin = 1'b1;
          end else begin
            state_d = S_PKT;
            held_d  = 1'b1;
          end
        end else begin
          inc_noslot = 1'b1;
          if (LOCK_ON_EMPTY != 0)  state_d = S_LOCK;
          else if (!bus.eth_eop)   state_d = S_DROP;
        end
      end else if (state_q == S_PKT) begin
        if (cnt_q < CW'(MAX_FLITS)) begin
          wr_en   = 1'b1;
          wr_addr = {slot_q, cnt_q[SLOT_LOG2-1:0]};
          cnt_d   = cnt_q + CW'(1);
          prev_d  = bus.eth_data;
          if (bus.eth_eop) begin
            fin     = 1'b1;
            state_d = S_IDLE;
            held_d  = 1'b0;
          end
        end else if (bus.eth_eop) begin
          free_a   = 1'b1;
          inc_over = 1'b1;
          state_d  = S_IDLE;
          held_d   = 1'b0;
        end else begin
          state_d = S_DROP;
        end
      end else if (state_q == S_DROP && bus.eth_eop) begin
        free_a   = held_q;
        inc_over = held_q;
        state_d  = S_IDLE;
        held_d   = 1'b0;
      end
    end
  end

  // Tail: the last TAIL_BYTES valid bytes; the previous flit backfills a short last flit.
  always_comb begin
    fin_id   = bus.eth_sop ? bus.emptylist_out_data : slot_q;
    tail_src = {(bus.eth_sop ? {DATA_W{1'b0}} : prev_q), bus.eth_data};
    push_hdr = bus.eth_sop ? bus.eth_data : hdr_q;
    push_meta.pktID        = fin_id;
    push_meta.flits        = bus.eth_sop ? CW'(1) : cnt_q + CW'(1);
    push_meta.empty        = bus.eth_empty;
    push_meta.last_7_bytes = TAIL_W'(tail_src >> {bus.eth_empty, 3'b000});
    push_en  = fin && room;
    free_b   = fin && !room;
    inc_full = free_b;
  end

  // Two frees can coincide (sop closes an open slot while its own 1-flit packet finds the
  // FIFO full); the younger one waits a cycle in a single-entry pending register.
  always_comb begin
    free_v    = 1'b0;
    free_id   = '0;
    pend_d    = 1'b0;
    pend_id_d = pend_id_q;
    if (pend_q) begin
      free_v  = 1'b1;
      free_id = pend_id_q;
      if (free_a || free_b) begin
        pend_d    = 1'b1;
        pend_id_d = free_a ? slot_q : fin_id;
      end
    end else if (free_a) begin
      free_v  = 1'b1;
      free_id = slot_q;
      if (free_b) begin
        pend_d    = 1'b1;
        pend_id_d = fin_id;
      end
    end else if (free_b) begin
      free_v  = 1'b1;
      free_id = fin_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      held_q      <= 1'b0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      prev_q      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      push_q      <= 1'b0;
      push_hdr_q  <= '0;
      push_meta_q <= '0;
      free_q      <= 1'b0;
      free_id_q   <= '0;
      pend_q      <= 1'b0;
      pend_id_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      prev_q    <= prev_d;
      wr_q      <= wr_en;
      if (wr_en) begin
        addr_q  <= wr_addr;
        wdata_q <= {bus.eth_sop, bus.eth_eop, bus.eth_empty, bus.eth_data};
      end
      push_q    <= push_en;
      if (push_en) begin
        push_hdr_q  <= push_hdr;
        push_meta_q <= push_meta;
      end
      free_q    <= free_v;
      free_id_q <= free_id;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      if (push_q) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push_q) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) begin
      hdr_mem[wr_ptr_q]  <= push_hdr_q;
      meta_mem[wr_ptr_q] <= push_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_noslot_q <= '0;
      cnt_over_q   <= '0;
      cnt_full_q   <= '0;
    end else begin
      if (inc_noslot && cnt_noslot_q != '1) cnt_noslot_q <= cnt_noslot_q + 32'd1;
      if (inc_over   && cnt_over_q   != '1) cnt_over_q   <= cnt_over_q   + 32'd1;
      if (inc_full   && cnt_full_q   != '1) cnt_full_q   <= cnt_full_q   + 32'd1;
    end
  end

  assign bus.emptylist_out_ready  = el_ready;
  assign bus.pktid_free_valid     = free_q;
  assign bus.pktid_free_data      = free_id_q;
  assign bus.pkt_buffer_write     = wr_q;
  assign bus.pkt_buffer_address   = addr_q;
  assign bus.pkt_buffer_writedata = wdata_q;
  assign bus.pkt_valid            = fifo_valid;
  assign bus.pkt_sop              = fifo_valid;
  assign bus.pkt_eop              = fifo_valid;
  assign bus.pkt_empty            = '0;
  assign bus.pkt_data             = fifo_valid ? hdr_mem[rd_ptr_q] : '0;
  assign bus.meta_valid           = fifo_valid;
  assign bus.meta_data            = fifo_valid ? meta_mem[rd_ptr_q] : '0;
  assign bus.cnt_drop_noslot      = cnt_noslot_q;
  assign bus.cnt_drop_oversize    = cnt_over_q;
  assign bus.cnt_drop_full        = cnt_full_q;
endmodule

// File: tb/tb_pkt_ingress_alloc.sv
// Directed bench for pkt_ingress_alloc: a packet-level byte-stream model predicts writes,
// frees, parser entries and drop counters; a negedge process compares every cycle.
module tb_pkt_ingress_alloc;
  localparam int unsigned DATA_W = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pkt_ingress_alloc_if #(.DATA_W(512), .EMPTY_W(6), .PKT_AWIDTH(12), .SLOT_LOG2(5),
                         .TAIL_BYTES(7)) bus ();

  pkt_ingress_alloc #(.DATA_W(512), .EMPTY_W(6), .PKT_AWIDTH(12), .SLOT_LOG2(5),
                      .TAIL_BYTES(7), .OUT_DEPTH(8), .LOCK_ON_EMPTY(0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int cyc; logic [16:0] addr; logic [519:0] data; } wr_t;
  typedef struct { int cyc; logic [11:0] id; } free_t;
  typedef struct { int cyc; logic [511:0] hdr; logic [79:0] meta; } meta_t;

  wr_t   exp_wr[$];
  free_t exp_free[$];
  meta_t exp_meta[$];
  logic [16:0] wr_log[$];

  int n_cmp = 0, n_err = 0;
  int m_noslot = 0, m_over = 0, m_full = 0;
  logic exp_el_ready = 1'b0;
  int last_eop_cyc = 0, pop_cyc = 0, n_pop = 0;
  logic [79:0] last_meta = '0;
  logic [11:0] last_free = '0;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int seed, input int k);
    return 8'(seed * 31 + k * 7 + 1);
  endfunction

  function automatic logic [511:0] mk_flit(input int seed, input int i, input int total);
    logic [511:0] d;
    for (int j = 0; j < 64; j++)
      d[511 - 8*j -: 8] = (64*i + j < total) ? pbyte(seed, 64*i + j) : 8'hEE;
    return d;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.eth_valid = 1'b0; bus.eth_sop = 1'b0; bus.eth_eop = 1'b0;
      bus.emptylist_out_valid = 1'b0; exp_el_ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Packet-level model: outcome follows from slot availability, length and queued entries.
  task automatic send_pkt(input int n, input int emp, input bit have_slot,
                          input logic [11:0] slot, input int seed);
    int total;
    logic [55:0] tail;
    logic [511:0] hdr, d;
    bit accept;
    total = n * 64 - emp;
    tail = '0;
    for (int t = 0; t < 7; t++)
      if (total - 7 + t >= 0) tail[55 - 8*t -: 8] = pbyte(seed, total - 7 + t);
    hdr = mk_flit(seed, 0, total);
    accept = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = mk_flit(seed, i, total);
      bus.eth_valid = 1'b1;
      bus.eth_sop   = (i == 0);
      bus.eth_eop   = (i == n - 1);
      bus.eth_empty = (i == n - 1) ? 6'(emp) : 6'd0;
      bus.eth_data  = d;
      bus.emptylist_out_valid = (i == 0) && have_slot;
      bus.emptylist_out_data  = (i == 0) ? slot : 12'd0;
      exp_el_ready = (i == 0) && have_slot;
      if (have_slot && i < 32)
        exp_wr.push_back('{cyc + 1, {slot, 5'(i)},
                           {(i == 0), (i == n - 1), bus.eth_empty, d}});
      if (i == n - 1) begin
        last_eop_cyc = cyc;
        if (have_slot && n > 32) exp_free.push_back('{cyc + 1, slot});
        else if (have_slot) begin
          accept = (exp_meta.size() < 8);
          if (accept) exp_meta.push_back('{cyc + 2, hdr, {slot, 6'(n), 6'(emp), tail}});
          else        exp_free.push_back('{cyc + 1, slot});
        end
      end
      @(posedge clk); #1;
      if (i == 0 && !have_slot) m_noslot++;
      if (i == n - 1 && have_slot && n > 32) m_over++;
      if (i == n - 1 && have_slot && n <= 32 && !accept) m_full++;
    end
    idle(0);
    bus.eth_valid = 1'b0; bus.eth_sop = 1'b0; bus.eth_eop = 1'b0;
    bus.emptylist_out_valid = 1'b0; exp_el_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_wr.size() + exp_free.size() + exp_meta.size()) != 0; i++)
      @(posedge clk);
    chk("drain_outstanding", 576'(exp_wr.size() + exp_free.size() + exp_meta.size()), 576'd0);
    #1;
    idle(2);
  endtask

  // Per-cycle compare against the model queues and counters.
  initial begin
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      chk("emptylist_ready", 576'(bus.emptylist_out_ready), 576'(exp_el_ready));
      if (bus.pkt_buffer_write) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 576'(bus.pkt_buffer_write), 576'd0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_cycle", 576'(cyc), 576'(w.cyc));
          chk("wr_addr", 576'(bus.pkt_buffer_address), 576'(w.addr));
          chk("wr_data", 576'(bus.pkt_buffer_writedata), 576'(w.data));
          wr_log.push_back(bus.pkt_buffer_address);
        end
      end
      if (bus.pktid_free_valid) begin
        if (exp_free.size() == 0) chk("free_unexpected", 576'(bus.pktid_free_valid), 576'd0);
        else begin
          free_t f;
          f = exp_free.pop_front();
          chk("free_cycle", 576'(cyc), 576'(f.cyc));
          chk("free_id", 576'(bus.pktid_free_data), 576'(f.id));
          last_free = bus.pktid_free_data;
        end
      end
      chk("cnt_noslot", 576'(bus.cnt_drop_noslot), 576'(m_noslot));
      chk("cnt_oversize", 576'(bus.cnt_drop_oversize), 576'(m_over));
      chk("cnt_full", 576'(bus.cnt_drop_full), 576'(m_full));
      if (bus.pkt_valid) begin
        chk("meta_valid_pair", 576'(bus.meta_valid), 576'd1);
        chk("pkt_sop_eop", 576'({bus.pkt_sop, bus.pkt_eop}), 576'(2'b11));
        chk("pkt_empty", 576'(bus.pkt_empty), 576'd0);
        if (bus.pkt_ready && bus.meta_ready) begin
          if (exp_meta.size() == 0) chk("pop_unexpected", 576'(bus.pkt_valid), 576'd0);
          else begin
            meta_t m;
            m = exp_meta.pop_front();
            chk("pop_not_early", 576'(cyc >= m.cyc), 576'd1);
            chk("pkt_data", 576'(bus.pkt_data), 576'(m.hdr));
            chk("meta_data", 576'(bus.meta_data), 576'(m.meta));
            last_meta = bus.meta_data;
            pop_cyc = cyc;
            n_pop++;
          end
        end
      end else begin
        chk("meta_valid_idle", 576'(bus.meta_valid), 576'd0);
      end
    end
  end

  initial begin
    int pops0;
    bus.eth_valid = 1'b0; bus.eth_sop = 1'b0; bus.eth_eop = 1'b0;
    bus.eth_data = '0; bus.eth_empty = '0;
    bus.emptylist_out_valid = 1'b0; bus.emptylist_out_data = '0;
    bus.pkt_ready = 1'b1; bus.meta_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_write", 576'(bus.pkt_buffer_write), 576'd0);
    chk("rst_addr", 576'(bus.pkt_buffer_address), 576'd0);
    chk("rst_wdata", 576'(bus.pkt_buffer_writedata), 576'd0);
    chk("rst_free", 576'({bus.pktid_free_valid, bus.pktid_free_data}), 576'd0);
    chk("rst_pkt_valid", 576'(bus.pkt_valid), 576'd0);
    chk("rst_pkt_data", 576'(bus.pkt_data), 576'd0);
    chk("rst_meta", 576'({bus.meta_valid, bus.meta_data}), 576'd0);
    chk("rst_el_ready", 576'(bus.emptylist_out_ready), 576'd0);
    chk("rst_counters", 576'({bus.cnt_drop_noslot, bus.cnt_drop_oversize, bus.cnt_drop_full}), 576'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 3-flit packet, slot 5, empty 10
    wr_log.delete();
    send_pkt(3, 10, 1'b1, 12'h005, 1);
    drain();
    chk("t1_nwr", 576'(wr_log.size()), 576'd3);
    if (wr_log.size() == 3) begin
      chk("t1_addr0", 576'(wr_log[0]), 576'h0A0);
      chk("t1_addr1", 576'(wr_log[1]), 576'h0A1);
      chk("t1_addr2", 576'(wr_log[2]), 576'h0A2);
    end
    chk("t1_latency", 576'(pop_cyc - last_eop_cyc), 576'd2);
    chk("t1_id", 576'(last_meta[79:68]), 576'h005);
    chk("t1_flits", 576'(last_meta[67:62]), 576'd3);
    chk("t1_empty", 576'(last_meta[61:56]), 576'd10);
    chk("t1_tail", 576'(last_meta[55:0]), 576'hE9F0F7FE050C13);

    // 1-flit packet, empty 60
    send_pkt(1, 60, 1'b1, 12'h00A, 2);
    drain();
    chk("t2_flits", 576'(last_meta[67:62]), 576'd1);
    chk("t2_tail", 576'(last_meta[55:0]), 576'h0000003F464D54);

    // 2-flit packet, empty 60 on the second flit
    send_pkt(2, 60, 1'b1, 12'h00B, 3);
    drain();
    chk("t3_tail", 576'(last_meta[55:0]), 576'h0910171E252C33);

    // 40-flit oversize packet, slot 7
    wr_log.delete();
    pops0 = n_pop;
    send_pkt(40, 0, 1'b1, 12'h007, 4);
    drain();
    chk("t4_nwr", 576'(wr_log.size()), 576'd32);
    chk("t4_free_id", 576'(last_free), 576'h007);
    chk("t4_oversize", 576'(bus.cnt_drop_oversize), 576'd1);
    chk("t4_no_meta", 576'(n_pop - pops0), 576'd0);

    // free list empty at sop, then a normal packet
    wr_log.delete();
    send_pkt(2, 5, 1'b0, 12'h000, 5);
    drain();
    chk("t5_nwr", 576'(wr_log.size()), 576'd0);
    chk("t5_noslot", 576'(bus.cnt_drop_noslot), 576'd1);
    send_pkt(3, 0, 1'b1, 12'h009, 6);
    drain();
    chk("t5_next_id", 576'(last_meta[79:68]), 576'h009);

    // 9 one-flit packets with the parser stalled: 8 queue, 9th dropped
    bus.pkt_ready = 1'b0; bus.meta_ready = 1'b0;
    pops0 = n_pop;
    for (int k = 0; k < 9; k++) send_pkt(1, 0, 1'b1, 12'(16 + k), 10 + k);
    idle(4);
    chk("t6_full", 576'(bus.cnt_drop_full), 576'd1);
    chk("t6_free_id", 576'(last_free), 576'h018);
    chk("t6_head_valid", 576'(bus.pkt_valid), 576'd1);
    chk("t6_head_id", 576'(bus.meta_data[79:68]), 576'h010);
    bus.pkt_ready = 1'b1;
    idle(3);
    chk("t6_hold_pop", 576'(n_pop - pops0), 576'd0);
    bus.meta_ready = 1'b1;
    drain();
    chk("t6_pops", 576'(n_pop - pops0), 576'd8);
    chk("t6_last_id", 576'(last_meta[79:68]), 576'h017);

    // back-to-back 1-flit packets with the parser ready
    pops0 = n_pop;
    for (int k = 0; k < 4; k++) send_pkt(1, 0, 1'b1, 12'(32 + k), 30 + k);
    drain();
    chk("t7_pops", 576'(n_pop - pops0), 576'd4);
    chk("t7_full_unchanged", 576'(bus.cnt_drop_full), 576'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
